// File: rtl/k12a_spi_pkg.sv
// Shared constants and FSM encoding for the k12a SPI mode-0 responder.
package k12a_spi_pkg;
  localparam int         SPI_BYTE_BITS = 8;
  localparam logic [7:0] DEF_IDLE_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_WAIT  = 3'd4
  } state_e;
endpackage

// File: rtl/k12a_sync.sv
// STAGES-deep single-bit synchronizer with a configurable reset value.
module k12a_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_sync <= {STAGES{RST_VAL}};
    else         r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/k12a_spi_responder.sv
// SPI mode-0 responder, oversampled in the local clock domain, byte valid/ready side.
// Define K12A_SPI_RESPONDER_STATUS_EN to add sticky underrun/overrun flags.
module k12a_spi_responder
  import k12a_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = DEF_IDLE_BYTE
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_spi_sck,
  input  logic       i_spi_mosi,
  input  logic       i_spi_ss_n,
  output logic       o_spi_miso,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
`ifdef K12A_SPI_RESPONDER_STATUS_EN
  output logic       o_underrun,
  output logic       o_overrun,
  input  logic       i_status_clear,
  input  logic       i_rx_ack,
`endif
  output logic       o_busy
);
  localparam logic [3:0] LAST_BIT = 4'(SPI_BYTE_BITS - 1);
  localparam logic [3:0] ALL_BITS = 4'(SPI_BYTE_BITS);

  logic w_sck_s, w_mosi_s, w_ss_s;
  logic r_sck_prev, r_ss_prev;
  logic w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall;

  state_e                   r_state;
  logic [SPI_BYTE_BITS-1:0] r_tx_shift, r_rx_shift, r_hold, r_rx_data;
  logic                     r_hold_full, r_miso, r_rx_valid;
  logic [3:0]               r_bit_cnt;
  logic                     w_tx_accept;

  // ss_n idles high, so its synchronizer resets high to avoid a false select.
  k12a_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .i_clock(i_clock), .i_reset(i_reset), .i_d(i_spi_sck),  .o_q(w_sck_s));
  k12a_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clock(i_clock), .i_reset(i_reset), .i_d(i_spi_mosi), .o_q(w_mosi_s));
  k12a_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .i_clock(i_clock), .i_reset(i_reset), .i_d(i_spi_ss_n), .o_q(w_ss_s));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sck_prev <= 1'b0;
      r_ss_prev  <= 1'b1;
    end else begin
      r_sck_prev <= w_sck_s;
      r_ss_prev  <= w_ss_s;
    end
  end

  assign w_sck_rise  =  w_sck_s & ~r_sck_prev;
  assign w_sck_fall  = ~w_sck_s &  r_sck_prev;
  assign w_ss_rise   =  w_ss_s  & ~r_ss_prev;
  assign w_ss_fall   = ~w_ss_s  &  r_ss_prev;
  assign w_tx_accept = i_tx_valid & ~r_hold_full;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_miso      <= 1'b0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_bit_cnt   <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      // Accept only fires when empty and LOAD only drains when full, so they never collide.
      if (w_tx_accept) begin
        r_hold      <= i_tx_data;
        r_hold_full <= 1'b1;
      end
      if (w_ss_rise) begin
        r_state   <= ST_IDLE;
        r_miso    <= 1'b0;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_miso <= 1'b0;
            if (w_ss_fall) r_state <= ST_LOAD;
          end
          ST_LOAD: begin
            if (r_hold_full) begin
              r_tx_shift  <= r_hold;
              r_miso      <= r_hold[SPI_BYTE_BITS-1];
              r_hold_full <= 1'b0;
            end else begin
              r_tx_shift  <= IDLE_BYTE;
              r_miso      <= IDLE_BYTE[SPI_BYTE_BITS-1];
            end
            r_bit_cnt <= '0;
            r_state   <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (w_sck_rise) begin
              r_rx_shift <= {r_rx_shift[SPI_BYTE_BITS-2:0], w_mosi_s};
              r_bit_cnt  <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == LAST_BIT) r_state <= ST_DONE;
            end else if (w_sck_fall && r_bit_cnt < ALL_BITS) begin
              r_tx_shift <= {r_tx_shift[SPI_BYTE_BITS-2:0], 1'b0};
              r_miso     <= r_tx_shift[SPI_BYTE_BITS-2];
            end
          end
          ST_DONE: begin
            r_rx_data  <= r_rx_shift;
            r_rx_valid <= 1'b1;
            r_bit_cnt  <= '0;
            r_state    <= ST_WAIT;
          end
          ST_WAIT: begin
            if (w_sck_fall) r_state <= ST_LOAD;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef K12A_SPI_RESPONDER_STATUS_EN
  logic r_underrun, r_overrun, r_rx_pending;
  logic w_load_idle, w_done;

  assign w_load_idle = (r_state == ST_LOAD) & ~r_hold_full & ~w_ss_rise;
  assign w_done      = (r_state == ST_DONE) & ~w_ss_rise;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_underrun   <= 1'b0;
      r_overrun    <= 1'b0;
      r_rx_pending <= 1'b0;
    end else begin
      if (w_done)        r_rx_pending <= 1'b1;
      else if (i_rx_ack) r_rx_pending <= 1'b0;
      if (i_status_clear) begin
        r_underrun <= 1'b0;
        r_overrun  <= 1'b0;
      end else begin
        if (w_load_idle)                         r_underrun <= 1'b1;
        if (w_done && r_rx_pending && !i_rx_ack) r_overrun  <= 1'b1;
      end
    end
  end

  assign o_underrun = r_underrun;
  assign o_overrun  = r_overrun;
`endif

  assign o_spi_miso = r_miso;
  assign o_tx_ready = ~r_hold_full;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_busy     = ~w_ss_s;
endmodule

// File: tb/tb_k12a_spi_responder.sv
// Directed bench for k12a_spi_responder: bus-level SPI master, rx scoreboard, literal checks.
module tb_k12a_spi_responder;
  logic       clk, rst, sck, mosi, ss_n, miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, busy;
`ifdef K12A_SPI_RESPONDER_STATUS_EN
  logic       underrun, overrun, status_clear, rx_ack;
`endif

  int checks = 0, errors = 0;
  int cyc = 0, rx_count = 0, last_rise_cyc = 0, last_rx_cyc = 0;
  logic [7:0] exp_rx[$];
  logic busy_prev = 1'b0, rxv_prev = 1'b0;

  k12a_spi_responder dut (
    .i_clock(clk), .i_reset(rst), .i_spi_sck(sck), .i_spi_mosi(mosi), .i_spi_ss_n(ss_n),
    .o_spi_miso(miso), .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid),
`ifdef K12A_SPI_RESPONDER_STATUS_EN
    .o_underrun(underrun), .o_overrun(overrun), .i_status_clear(status_clear), .i_rx_ack(rx_ack),
`endif
    .o_busy(busy));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every received byte must match the next byte the master sent in a complete frame.
  always @(negedge clk) begin
    if (rst) begin
      busy_prev = 1'b0;
      rxv_prev  = 1'b0;
    end else begin
      if (rx_valid) begin
        rx_count++;
        last_rx_cyc = cyc;
        if (exp_rx.size() == 0) check("rx_unexpected", 32'(rx_data), 32'h1FF);
        else                    check("rx_data_sb", 32'(rx_data), 32'(exp_rx.pop_front()));
        check("rx_valid_pulse", 32'(rxv_prev), 32'h0);
      end
      if (!busy && !busy_prev) check("miso_idle", 32'(miso), 32'h0);
      busy_prev = busy;
      rxv_prev  = rx_valid;
    end
  end

  task automatic offer(input logic [7:0] d);
    @(negedge clk); tx_data = d; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
  endtask

  task automatic sel();
    @(negedge clk); ss_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic desel();
    repeat (4) @(negedge clk); ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Mode 0, MSB first, 4 clocks per sck phase; miso captured just before each rise.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = mo[i];
      repeat (4) @(negedge clk);
      mi = {mi[6:0], miso};
      sck = 1'b1;
      last_rise_cyc = cyc;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m1, m2;
    int n0;
    rst = 1'b1; sck = 1'b0; mosi = 1'b0; ss_n = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
`ifdef K12A_SPI_RESPONDER_STATUS_EN
    status_clear = 1'b0; rx_ack = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_tx_ready", 32'(tx_ready), 32'h1);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Preloaded A5 out, 3C in; latency pinned to SYNC_STAGES+2.
    offer(8'hA5);
    check("t1_tx_ready_drop", 32'(tx_ready), 32'h0);
    exp_rx.push_back(8'h3C);
    sel();
    check("t1_busy", 32'(busy), 32'h1);
    xfer(8'h3C, 8, m1);
    desel();
    check("t1_miso", 32'(m1), 32'hA5);
    check("t1_rx_data", 32'(rx_data), 32'h3C);
    check("t1_rx_count", 32'(rx_count), 32'd1);
    check("t1_latency", 32'(last_rx_cyc - last_rise_cyc), 32'd4);
    check("t1_tx_ready", 32'(tx_ready), 32'h1);

    // Empty holding register: idle byte goes out.
`ifdef K12A_SPI_RESPONDER_STATUS_EN
    @(negedge clk); status_clear = 1'b1; @(negedge clk); status_clear = 1'b0;
    check("t2_underrun_clr", 32'(underrun), 32'h0);
`endif
    exp_rx.push_back(8'h00);
    sel();
    xfer(8'h00, 8, m1);
    desel();
    check("t2_miso", 32'(m1), 32'hFF);
    check("t2_rx_data", 32'(rx_data), 32'h00);
`ifdef K12A_SPI_RESPONDER_STATUS_EN
    check("t2_underrun", 32'(underrun), 32'h1);
`endif

    // Back-to-back bytes; second tx byte offered while the first is shifting.
    n0 = rx_count;
    offer(8'h11);
    exp_rx.push_back(8'hA1);
    exp_rx.push_back(8'h5E);
    sel();
    fork
      xfer(8'hA1, 8, m1);
      begin repeat (20) @(negedge clk); offer(8'h22); end
    join
    xfer(8'h5E, 8, m2);
    desel();
    check("t3_miso0", 32'(m1), 32'h11);
    check("t3_miso1", 32'(m2), 32'h22);
    check("t3_rx_pulses", 32'(rx_count - n0), 32'd2);

    // Aborted partial byte, then a clean frame.
    n0 = rx_count;
    sel();
    xfer(8'hF0, 4, m1);
    desel();
    check("t4_no_rx", 32'(rx_count - n0), 32'd0);
    exp_rx.push_back(8'h81);
    sel();
    xfer(8'h81, 8, m1);
    desel();
    check("t4_rx_data", 32'(rx_data), 32'h81);
    check("t4_miso", 32'(m1), 32'hFF);

    // tx_valid lands on the LOAD cycle: that byte waits for the next load.
    exp_rx.push_back(8'h12);
    exp_rx.push_back(8'h34);
    @(negedge clk); ss_n = 1'b0;
    repeat (3) @(negedge clk);
    tx_data = 8'h5A; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    xfer(8'h12, 8, m1);
    xfer(8'h34, 8, m2);
    desel();
    check("t5_miso0", 32'(m1), 32'hFF);
    check("t5_miso1", 32'(m2), 32'h5A);

    // Async reset mid-byte.
    sel();
    offer(8'h77);
    check("t6_tx_ready_pre", 32'(tx_ready), 32'h0);
    xfer(8'hF0, 3, m1);
    sck = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_miso", 32'(miso), 32'h0);
    check("t6_tx_ready", 32'(tx_ready), 32'h1);
    check("t6_rx_data", 32'(rx_data), 32'h00);
    check("t6_rx_valid", 32'(rx_valid), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    exp_rx.push_back(8'hC3);
    sel();
    xfer(8'hC3, 8, m1);
    desel();
    check("t6_rx_after", 32'(rx_data), 32'hC3);
    check("t6_miso_after", 32'(m1), 32'hFF);
    check("sb_drained", 32'(exp_rx.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
